// File: rtl/uart_wb_cmd_ctrl.sv
// UART byte-stream command sequencer driving Wishbone read/write bursts.
// Optional ack timeout is enabled by defining UART_WB_TIMEOUT_EN.
module uart_wb_cmd_ctrl #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  output logic        busy,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE, S_SIZE, S_ADDR, S_WDATA, S_WB_WR, S_WB_RD, S_TX
  } state_t;

  state_t      state_q, state_d;
  logic        is_wr_q, is_wr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] data_q, data_d;
  logic        cyc_q, cyc_d;
  logic        txv_q, txv_d;
  logic        err_q, err_d;

  logic        bus_st;
  logic        bus_done;
  logic        tx_take;
  logic        tmo_hit;

`ifdef UART_WB_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);
  logic [31:0] tmo_q, tmo_d;

  assign tmo_hit = (tmo_q == TMO_LAST);

  always_comb begin
    tmo_d = '0;
    if (bus_st && cyc_q && !bus_done) tmo_d = tmo_q + 32'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) tmo_q <= '0;
    else         tmo_q <= tmo_d;
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    is_wr_d  = is_wr_q;
    cnt_d    = cnt_q;
    bcnt_d   = bcnt_q;
    adr_d    = adr_q;
    data_d   = data_q;
    err_d    = 1'b0;
    bus_st   = (state_q == S_WB_WR) || (state_q == S_WB_RD);
    bus_done = bus_st && cyc_q && (wb_ack_i || tmo_hit);
    tx_take  = (state_q == S_TX) && txv_q && tx_ready;
    // Strobes follow the state one edge late, so cyc drops the edge after ack
    cyc_d    = bus_st;
    txv_d    = (state_q == S_TX) && !(tx_take && (bcnt_q == 2'd3));

    if (rx_valid && (bus_st || (state_q == S_TX))) err_d = 1'b1;
    if (bus_done && !wb_ack_i) err_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (rx_valid && ((rx_data == 8'h01) || (rx_data == 8'h02))) begin
          is_wr_d = (rx_data == 8'h01);
          state_d = S_SIZE;
        end
      end
      S_SIZE: begin
        if (rx_valid) begin
          cnt_d   = rx_data;
          bcnt_d  = '0;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (rx_valid) begin
          adr_d  = {adr_q[23:0], rx_data};
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            if (cnt_q == 8'd0) state_d = S_IDLE;
            else if (is_wr_q)  state_d = S_WDATA;
            else               state_d = S_WB_RD;
          end
        end
      end
      S_WDATA: begin
        if (rx_valid) begin
          data_d = {data_q[23:0], rx_data};
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) state_d = S_WB_WR;
        end
      end
      S_WB_WR: begin
        if (bus_done) begin
          adr_d   = adr_q + 32'd4;
          cnt_d   = cnt_q - 8'd1;
          bcnt_d  = '0;
          state_d = (cnt_q == 8'd1) ? S_IDLE : S_WDATA;
        end
      end
      S_WB_RD: begin
        if (bus_done) begin
          adr_d   = adr_q + 32'd4;
          cnt_d   = cnt_q - 8'd1;
          bcnt_d  = '0;
          data_d  = wb_ack_i ? wb_dat_i : 32'hDEAD_BEEF;
          state_d = S_TX;
        end
      end
      S_TX: begin
        if (tx_take) begin
          data_d = {data_q[23:0], 8'h00};
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) state_d = (cnt_q == 8'd0) ? S_IDLE : S_WB_RD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      is_wr_q <= 1'b0;
      cnt_q   <= '0;
      bcnt_q  <= '0;
      adr_q   <= '0;
      data_q  <= '0;
      cyc_q   <= 1'b0;
      txv_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      is_wr_q <= is_wr_d;
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
      adr_q   <= adr_d;
      data_q  <= data_d;
      cyc_q   <= cyc_d;
      txv_q   <= txv_d;
      err_q   <= err_d;
    end
  end

  assign tx_data  = data_q[31:24];
  assign tx_valid = txv_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = data_q;
  assign wb_we_o  = cyc_q & is_wr_q;
  assign wb_sel_o = 4'hF;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign busy     = (state_q != S_IDLE);
  assign err      = err_q;

endmodule

// File: tb/tb_uart_wb_cmd_ctrl.sv
// Self-checking bench for uart_wb_cmd_ctrl: Wishbone slave, UART TX sink and
// a transaction-level reference model of the command protocol.
module tb_uart_wb_cmd_ctrl;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        resetn;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_cyc_o, wb_stb_o, wb_ack_i;
  logic        busy, err;

  uart_wb_cmd_ctrl #(.TIMEOUT(TMO)) dut (
    .clk(clk), .resetn(resetn), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
    logic [3:0]  sel;
    logic        stb;
  } txn_t;

  int n_cmp = 0;
  int n_fail = 0;

  txn_t        txn_log[$];
  logic [7:0]  tx_log[$];
  logic [31:0] rd_q[$];
  logic [31:0] wr_words[$];
  int slave_delay_max = 3;
  bit noack = 0;
  int tx_mode = 0;
  int stab_viol = 0;
  int err_cnt = 0;
  int stb_viol = 0;
  int ack_timing_viol = 0;
  int txv_timing_viol = 0;
  int cyc_high_len = 0;

  // Wishbone slave: records each cycle once, acks after a random delay
  initial begin : slave
    int d;
    bit rd;
    txn_t t;
    wb_ack_i = 1'b0;
    wb_dat_i = '0;
    forever begin
      @(negedge clk);
      if (wb_cyc_o === 1'b1) begin
        t.adr = wb_adr_o; t.dat = wb_dat_o; t.we = wb_we_o;
        t.sel = wb_sel_o; t.stb = wb_stb_o;
        txn_log.push_back(t);
        rd = !wb_we_o;
        if (noack) begin
          cyc_high_len = 1;
          while (wb_cyc_o === 1'b1 && cyc_high_len < 5000) begin
            @(negedge clk);
            if (wb_cyc_o === 1'b1) cyc_high_len++;
          end
        end else begin
          d = $urandom_range(slave_delay_max, 0);
          repeat (d) @(negedge clk);
          wb_dat_i = (rd && rd_q.size() > 0) ? rd_q.pop_front() : $urandom;
          wb_ack_i = 1'b1;
          @(negedge clk);
          wb_ack_i = 1'b0;
          wb_dat_i = '0;
          if (wb_cyc_o !== 1'b1) ack_timing_viol++;
          if (rd && tx_valid !== 1'b0) txv_timing_viol++;
          @(negedge clk);
          if (wb_cyc_o !== 1'b0) ack_timing_viol++;
          if (rd && tx_valid !== 1'b1) txv_timing_viol++;
        end
      end
    end
  end

  // UART TX sink with selectable ready pattern and hold-stability tracking
  initial begin : sink
    bit pend;
    logic [7:0] pend_data;
    int stall_cnt;
    pend = 0; pend_data = '0; stall_cnt = 0;
    tx_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (pend && (tx_valid !== 1'b1 || tx_data !== pend_data)) stab_viol++;
      case (tx_mode)
        0: tx_ready = 1'b1;
        1: tx_ready = 1'($urandom_range(1, 0));
        default: begin
          if (tx_valid === 1'b1) begin
            if (stall_cnt < 5) begin tx_ready = 1'b0; stall_cnt++; end
            else begin tx_ready = 1'b1; stall_cnt = 0; end
          end else tx_ready = 1'b0;
        end
      endcase
      if (tx_valid === 1'b1 && tx_ready) begin
        tx_log.push_back(tx_data);
        pend = 0;
      end else begin
        pend = (tx_valid === 1'b1);
        pend_data = tx_data;
      end
    end
  end

  initial begin : mon
    forever begin
      @(negedge clk);
      if (err === 1'b1) err_cnt++;
      if (wb_cyc_o !== wb_stb_o) stb_viol++;
    end
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_bus(output bit ok);
    int i;
    ok = 0;
    for (i = 0; i < 1000 && wb_cyc_o !== 1'b1; i++) @(negedge clk);
    for (i = 0; i < 1000; i++) begin
      if (wb_cyc_o === 1'b0) begin ok = 1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      if (busy === 1'b0 && wb_cyc_o === 1'b0) begin ok = 1; break; end
      @(negedge clk);
    end
  endtask

  task automatic do_frame(input bit wr, input logic [7:0] size,
                          input logic [31:0] addr, input int gap_max, output bit ok);
    logic [7:0]  hdr [6];
    logic [31:0] d;
    bit ok2;
    hdr[0] = wr ? 8'h01 : 8'h02; hdr[1] = size;
    hdr[2] = addr[31:24]; hdr[3] = addr[23:16]; hdr[4] = addr[15:8]; hdr[5] = addr[7:0];
    ok = 1;
    for (int i = 0; i < 6; i++) send_byte(hdr[i], $urandom_range(gap_max, 0));
    if (wr) begin
      for (int w = 0; w < int'(size); w++) begin
        d = wr_words[w];
        for (int b = 0; b < 4; b++) send_byte(d[31-8*b -: 8], (b == 3) ? 0 : $urandom_range(gap_max, 0));
        wait_bus(ok2);
        if (!ok2) ok = 0;
      end
    end
    wait_idle(ok2);
    if (!ok2) ok = 0;
  endtask

  task automatic clear_logs();
    txn_log.delete(); tx_log.delete(); rd_q.delete(); wr_words.delete();
    err_cnt = 0; stab_viol = 0; ack_timing_viol = 0; txv_timing_viol = 0; stb_viol = 0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; rx_valid = 1'b0; rx_data = '0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    n_cmp++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %0h want 00", tx_data); end
    n_cmp++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %0b want 0", tx_valid); end
    n_cmp++; if (wb_adr_o !== 32'h0) begin n_fail++; $display("FAIL reset_adr: got %0h want 0", wb_adr_o); end
    n_cmp++; if (wb_dat_o !== 32'h0) begin n_fail++; $display("FAIL reset_dat: got %0h want 0", wb_dat_o); end
    n_cmp++; if (wb_we_o !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %0b want 0", wb_we_o); end
    n_cmp++; if (wb_sel_o !== 4'hF) begin n_fail++; $display("FAIL reset_sel: got %0h want f", wb_sel_o); end
    n_cmp++; if ({wb_cyc_o, wb_stb_o} !== 2'b00) begin n_fail++; $display("FAIL reset_cyc_stb: got %0b want 00", {wb_cyc_o, wb_stb_o}); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0b want 0", err); end
  endtask

  task automatic test_write_basic();
    logic [7:0] bytes [9];
    logic c0, c1;
    bit ok;
    clear_logs(); tx_mode = 0;
    bytes = '{8'h01, 8'h01, 8'h00, 8'h40, 8'h00, 8'h24, 8'h77, 8'h55, 8'h55};
    for (int i = 0; i < 9; i++) send_byte(bytes[i], 0);
    rx_data = 8'hAB; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    c0 = wb_cyc_o;
    @(negedge clk);
    c1 = wb_cyc_o;
    n_cmp++; if ({c0, c1} !== 2'b01) begin n_fail++; $display("FAIL wr_cyc_rise: got %0b want 01", {c0, c1}); end
    wait_idle(ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL wr_idle_timeout: got busy %0b want 0", busy); end
    n_cmp++; if (txn_log.size() !== 1) begin n_fail++; $display("FAIL wr_txn_count: got %0d want 1", txn_log.size()); end
    if (txn_log.size() > 0) begin
      n_cmp++; if (txn_log[0].adr !== 32'h0040_0024) begin n_fail++; $display("FAIL wr_adr: got %0h want 00400024", txn_log[0].adr); end
      n_cmp++; if (txn_log[0].dat !== 32'h7755_55AB) begin n_fail++; $display("FAIL wr_dat: got %0h want 775555ab", txn_log[0].dat); end
      n_cmp++; if ({txn_log[0].we, txn_log[0].sel, txn_log[0].stb} !== 6'b1_1111_1) begin n_fail++; $display("FAIL wr_we_sel_stb: got %0b want 111111", {txn_log[0].we, txn_log[0].sel, txn_log[0].stb}); end
    end
    n_cmp++; if (ack_timing_viol !== 0) begin n_fail++; $display("FAIL wr_cyc_fall_timing: got %0d want 0", ack_timing_viol); end
  endtask

  task automatic test_read_stall();
    logic [7:0] exp [4];
    bit ok;
    clear_logs(); tx_mode = 2;
    rd_q.push_back(32'h7755_55AB);
    exp = '{8'h77, 8'h55, 8'h55, 8'hAB};
    do_frame(1'b0, 8'd1, 32'h0040_0024, 2, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL rd_timeout: got busy %0b want 0", busy); end
    n_cmp++; if (tx_log.size() !== 4) begin n_fail++; $display("FAIL rd_tx_count: got %0d want 4", tx_log.size()); end
    for (int i = 0; i < 4 && i < tx_log.size(); i++) begin
      n_cmp++; if (tx_log[i] !== exp[i]) begin n_fail++; $display("FAIL rd_tx_byte%0d: got %0h want %0h", i, tx_log[i], exp[i]); end
    end
    n_cmp++; if (stab_viol !== 0) begin n_fail++; $display("FAIL rd_tx_stable: got %0d changes want 0", stab_viol); end
    n_cmp++; if (txv_timing_viol !== 0) begin n_fail++; $display("FAIL rd_txv_timing: got %0d want 0", txv_timing_viol); end
    if (txn_log.size() > 0) begin
      n_cmp++; if ({txn_log[0].adr, txn_log[0].we} !== {32'h0040_0024, 1'b0}) begin n_fail++; $display("FAIL rd_adr_we: got %0h/%0b want 00400024/0", txn_log[0].adr, txn_log[0].we); end
    end
    tx_mode = 0;
  endtask

  task automatic test_wrap();
    bit ok;
    clear_logs();
    wr_words.push_back(32'h1122_3344); wr_words.push_back(32'h5566_7788);
    do_frame(1'b1, 8'd2, 32'hFFFF_FFFC, 1, ok);
    n_cmp++; if (!ok || txn_log.size() !== 2) begin n_fail++; $display("FAIL wrap_count: got %0d (ok %0b) want 2", txn_log.size(), ok); end
    if (txn_log.size() == 2) begin
      n_cmp++; if ({txn_log[0].adr, txn_log[0].dat} !== {32'hFFFF_FFFC, 32'h1122_3344}) begin n_fail++; $display("FAIL wrap_w0: got %0h/%0h want fffffffc/11223344", txn_log[0].adr, txn_log[0].dat); end
      n_cmp++; if ({txn_log[1].adr, txn_log[1].dat} !== {32'h0000_0000, 32'h5566_7788}) begin n_fail++; $display("FAIL wrap_w1: got %0h/%0h want 0/55667788", txn_log[1].adr, txn_log[1].dat); end
    end
  endtask

  task automatic test_bad_cmd_err();
    logic [31:0] w;
    bit ok;
    int i;
    clear_logs(); tx_mode = 2;
    send_byte(8'h07, 3);
    n_cmp++; if ({busy, err_cnt != 0} !== 2'b00) begin n_fail++; $display("FAIL badcmd_ignored: got busy %0b err_cycles %0d want 0/0", busy, err_cnt); end
    w = $urandom;
    rd_q.push_back(w);
    for (i = 0; i < 6; i++) send_byte((i == 0) ? 8'h02 : (i == 1) ? 8'h01 : 8'h00, 0);
    for (i = 0; i < 200 && tx_valid !== 1'b1; i++) @(negedge clk);
    send_byte(8'h5A, 0);
    wait_idle(ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL inject_timeout: got busy %0b want 0", busy); end
    n_cmp++; if (err_cnt !== 1) begin n_fail++; $display("FAIL inject_err_pulse: got %0d cycles want 1", err_cnt); end
    n_cmp++; if (tx_log.size() !== 4) begin n_fail++; $display("FAIL inject_tx_count: got %0d want 4", tx_log.size()); end
    for (i = 0; i < 4 && i < tx_log.size(); i++) begin
      n_cmp++; if (tx_log[i] !== w[31-8*i -: 8]) begin n_fail++; $display("FAIL inject_tx_byte%0d: got %0h want %0h", i, tx_log[i], w[31-8*i -: 8]); end
    end
    if (txn_log.size() > 0) begin
      n_cmp++; if (txn_log[0].adr !== 32'h0) begin n_fail++; $display("FAIL inject_adr: got %0h want 0", txn_log[0].adr); end
    end
    tx_mode = 0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] base, w;
    logic [7:0] exp_b [$];
    int cnt, i;
    bit ok;
    clear_logs(); tx_mode = 0;
    base = $urandom;
    for (i = 0; i < 3; i++) begin
      w = $urandom; rd_q.push_back(w);
      for (int b = 0; b < 4; b++) exp_b.push_back(w[31-8*b -: 8]);
    end
    send_byte(8'h02, 0); send_byte(8'h03, 0);
    for (i = 0; i < 4; i++) send_byte(base[31-8*i -: 8], 0);
    for (i = 0; i < 300 && tx_valid !== 1'b1; i++) @(negedge clk);
    cnt = 0;
    repeat (4) begin if (tx_valid === 1'b1) cnt++; @(negedge clk); end
    n_cmp++; if ({cnt, tx_valid} !== {32'd4, 1'b0}) begin n_fail++; $display("FAIL b2b_tx_burst: got %0d cycles then %0b want 4 then 0", cnt, tx_valid); end
    wait_idle(ok);
    n_cmp++; if (!ok || tx_log.size() !== 12) begin n_fail++; $display("FAIL b2b_tx_count: got %0d want 12", tx_log.size()); end
    for (i = 0; i < 12 && i < tx_log.size(); i++) begin
      n_cmp++; if (tx_log[i] !== exp_b[i]) begin n_fail++; $display("FAIL b2b_tx_byte%0d: got %0h want %0h", i, tx_log[i], exp_b[i]); end
    end
    for (i = 0; i < 3 && i < txn_log.size(); i++) begin
      n_cmp++; if (txn_log[i].adr !== base + 32'(4 * i)) begin n_fail++; $display("FAIL b2b_adr%0d: got %0h want %0h", i, txn_log[i].adr, base + 32'(4 * i)); end
    end
  endtask

  task automatic test_random();
    txn_t exp_txn [$];
    logic [7:0] exp_tx [$];
    txn_t t;
    logic [31:0] addr, w;
    logic [7:0] size;
    bit wr, ok, all_ok;
    clear_logs(); all_ok = 1;
    for (int f = 0; f < 14; f++) begin
      wr = 1'($urandom_range(1, 0));
      size = 8'($urandom_range(3, 0));
      addr = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC)) : ($urandom & ~32'h3);
      tx_mode = $urandom_range(1, 0);
      slave_delay_max = $urandom_range(4, 0);
      wr_words.delete();
      if ($urandom_range(2, 0) == 0) send_byte(8'($urandom_range(255, 3)), 1);
      for (int i = 0; i < int'(size); i++) begin
        w = $urandom;
        t.adr = addr + 32'(4 * i); t.dat = w; t.we = wr; t.sel = 4'hF; t.stb = 1'b1;
        exp_txn.push_back(t);
        if (wr) wr_words.push_back(w);
        else begin
          rd_q.push_back(w);
          for (int b = 0; b < 4; b++) exp_tx.push_back(w[31-8*b -: 8]);
        end
      end
      do_frame(wr, size, addr, 2, ok);
      if (!ok) all_ok = 0;
    end
    n_cmp++; if (!all_ok) begin n_fail++; $display("FAIL rand_timeout: got stuck frame want all complete"); end
    n_cmp++; if (txn_log.size() !== exp_txn.size()) begin n_fail++; $display("FAIL rand_txn_count: got %0d want %0d", txn_log.size(), exp_txn.size()); end
    for (int i = 0; i < exp_txn.size() && i < txn_log.size(); i++) begin
      n_cmp++;
      if (txn_log[i].adr !== exp_txn[i].adr || txn_log[i].we !== exp_txn[i].we || txn_log[i].sel !== 4'hF ||
          txn_log[i].stb !== 1'b1 || (exp_txn[i].we && txn_log[i].dat !== exp_txn[i].dat)) begin
        n_fail++;
        $display("FAIL rand_txn%0d: got adr %0h dat %0h we %0b want adr %0h dat %0h we %0b", i,
                 txn_log[i].adr, txn_log[i].dat, txn_log[i].we, exp_txn[i].adr, exp_txn[i].dat, exp_txn[i].we);
      end
    end
    n_cmp++; if (tx_log.size() !== exp_tx.size()) begin n_fail++; $display("FAIL rand_tx_count: got %0d want %0d", tx_log.size(), exp_tx.size()); end
    for (int i = 0; i < exp_tx.size() && i < tx_log.size(); i++) begin
      n_cmp++; if (tx_log[i] !== exp_tx[i]) begin n_fail++; $display("FAIL rand_tx%0d: got %0h want %0h", i, tx_log[i], exp_tx[i]); end
    end
    n_cmp++; if ({err_cnt, stb_viol, ack_timing_viol, txv_timing_viol} !== 128'd0) begin n_fail++; $display("FAIL rand_side: got err %0d stb %0d ackt %0d txvt %0d want all 0", err_cnt, stb_viol, ack_timing_viol, txv_timing_viol); end
    tx_mode = 0; slave_delay_max = 3;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int i;
    clear_logs(); noack = 1;
    send_byte(8'h02, 0); send_byte(8'h01, 0);
    for (i = 0; i < 4; i++) send_byte(8'h10, 0);
    for (i = 0; i < 100 && wb_cyc_o !== 1'b1; i++) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    n_cmp++; if ({wb_cyc_o, wb_stb_o, tx_valid, busy} !== 4'b0000) begin n_fail++; $display("FAIL rstmid_async: got cyc/stb/txv/busy %0b want 0000", {wb_cyc_o, wb_stb_o, tx_valid, busy}); end
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    noack = 0;
    @(negedge clk);
    clear_logs();
    wr_words.push_back(32'hCAFE_F00D);
    do_frame(1'b1, 8'd1, 32'h0000_1234, 0, ok);
    n_cmp++; if (!ok || txn_log.size() !== 1) begin n_fail++; $display("FAIL rstmid_count: got %0d want 1", txn_log.size()); end
    if (txn_log.size() > 0) begin
      n_cmp++; if ({txn_log[0].adr, txn_log[0].dat, txn_log[0].we} !== {32'h0000_1234, 32'hCAFE_F00D, 1'b1}) begin n_fail++; $display("FAIL rstmid_txn: got %0h/%0h/%0b want 1234/cafef00d/1", txn_log[0].adr, txn_log[0].dat, txn_log[0].we); end
    end
  endtask

`ifdef UART_WB_TIMEOUT_EN
  task automatic test_timeout();
    logic [7:0] exp [4];
    bit ok;
    clear_logs(); noack = 1; tx_mode = 0;
    exp = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    do_frame(1'b0, 8'd1, 32'h0000_0100, 0, ok);
    noack = 0;
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL tmo_stuck: got busy %0b want 0", busy); end
    n_cmp++; if (cyc_high_len !== TMO + 1) begin n_fail++; $display("FAIL tmo_cyc_len: got %0d want %0d", cyc_high_len, TMO + 1); end
    n_cmp++; if (err_cnt !== 1) begin n_fail++; $display("FAIL tmo_err: got %0d want 1", err_cnt); end
    n_cmp++; if (tx_log.size() !== 4) begin n_fail++; $display("FAIL tmo_tx_count: got %0d want 4", tx_log.size()); end
    for (int i = 0; i < 4 && i < tx_log.size(); i++) begin
      n_cmp++; if (tx_log[i] !== exp[i]) begin n_fail++; $display("FAIL tmo_tx%0d: got %0h want %0h", i, tx_log[i], exp[i]); end
    end
  endtask
`endif

  initial begin
    resetn = 1'b0; rx_valid = 1'b0; rx_data = '0;
    @(negedge clk);
    test_reset();
    test_write_basic();
    test_read_stall();
    test_wrap();
    test_bad_cmd_err();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef UART_WB_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
